// File: rtl/baseline_pkg.sv
// Shared definitions for the long-term amplitude baseline datapath.
package baseline_pkg;

  // Default input sample width (two's complement).
  localparam int DEF_DATA_WIDTH = 16;

  // Absolute value of a sign-extended sample of width w, saturated so that the
  // most negative code maps to the largest positive code (2**(w-1)-1).
  function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int w);
    logic [31:0] lim;
    logic [31:0] mag;
    lim = (32'd1 << (w - 1)) - 32'd1;
    if (x < 0) mag = -x;
    else       mag = x;
    if (mag > lim) mag = lim;
    return mag;
  endfunction

endpackage

// File: rtl/baseline_block_acc.sv
// Block summer: adds 2**LOG2_N valid inputs and emits their total as a
// one-cycle blk_valid pulse, then restarts from zero.
module baseline_block_acc
  import baseline_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 25,
  parameter int LOG2_N = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  i_in,
  input  logic             i_in_valid,
  output logic [OUT_W-1:0] o_blk,
  output logic             o_blk_valid
);

  logic [OUT_W-1:0]  r_acc;
  logic [LOG2_N-1:0] r_cnt;
  logic [OUT_W-1:0]  w_in_ext;

  assign w_in_ext = OUT_W'(i_in);

  // Accumulate valid inputs; the last input of a block is folded straight into the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      o_blk       <= '0;
      o_blk_valid <= 1'b0;
    end else begin
      o_blk_valid <= 1'b0;
      if (i_in_valid) begin
        if (r_cnt == '1) begin
          o_blk       <= r_acc + w_in_ext;
          o_blk_valid <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
        end else begin
          r_acc <= r_acc + w_in_ext;
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/baseline_core.sv
// Long-term amplitude baseline: rectify, three cascaded block sums, then a
// sliding-window sum over the most recent stage-3 blocks.
module baseline_core
  import baseline_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int W1         = 25,
  parameter int W2         = 28,
  parameter int W3         = 31,
  parameter int W4         = 34
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic                         en,
  output logic [W4-1:0]                dout
);

  localparam int LOG2_N4 = W4 - W3;
  localparam int N4      = 1 << LOG2_N4;

  logic [DATA_WIDTH-1:0] w_mag_p0;
  logic [W1-1:0]         w_blk_p1;
  logic                  w_vld_p1;
  logic [W2-1:0]         w_blk_p2;
  logic                  w_vld_p2;
  logic [W3-1:0]         w_blk_p3;
  logic                  w_vld_p3;
  logic [W4-1:0]         w_sum_next;

  logic [W3-1:0]      r_buf [N4];
  logic [LOG2_N4-1:0] r_ptr;
  logic [W4-1:0]      r_sum;

  // Stage 0 -> 1: saturating rectifier feeding the per-sample block sum
  assign w_mag_p0 = DATA_WIDTH'(sat_abs(32'(din), DATA_WIDTH));

  baseline_block_acc #(.IN_W(DATA_WIDTH), .OUT_W(W1), .LOG2_N(W1 - DATA_WIDTH)) u_stage1 (
    .clk(clk), .rst(rst), .i_in(w_mag_p0), .i_in_valid(en),
    .o_blk(w_blk_p1), .o_blk_valid(w_vld_p1)
  );

  // Stage 1 -> 2
  baseline_block_acc #(.IN_W(W1), .OUT_W(W2), .LOG2_N(W2 - W1)) u_stage2 (
    .clk(clk), .rst(rst), .i_in(w_blk_p1), .i_in_valid(w_vld_p1),
    .o_blk(w_blk_p2), .o_blk_valid(w_vld_p2)
  );

  // Stage 2 -> 3
  baseline_block_acc #(.IN_W(W2), .OUT_W(W3), .LOG2_N(W3 - W2)) u_stage3 (
    .clk(clk), .rst(rst), .i_in(w_blk_p2), .i_in_valid(w_vld_p2),
    .o_blk(w_blk_p3), .o_blk_valid(w_vld_p3)
  );

  // Stage 3 -> 4: sliding window; empty slots hold 0 so the window fills without a special case
  assign w_sum_next = r_sum + W4'(w_blk_p3) - W4'(r_buf[r_ptr]);

  // Replace the oldest block in the circular buffer and update the running window sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N4; i++) r_buf[i] <= '0;
      r_ptr <= '0;
      r_sum <= '0;
    end else if (w_vld_p3) begin
      r_buf[r_ptr] <= w_blk_p3;
      r_ptr        <= r_ptr + 1'b1;
      r_sum        <= w_sum_next;
    end
  end

  assign dout = r_sum;

endmodule

// File: tb/tb_baseline_core.sv
// Directed bench for baseline_core, built with reduced block sizes
// (N1=8, N2=4, N3=4, N4=8 -> 128 samples per stage-3 block) so every
// scenario fits a short run; expected values scale accordingly.
module tb_baseline_core;

  localparam int DW  = 16;
  localparam int W1  = 19;
  localparam int W2  = 21;
  localparam int W3  = 23;
  localparam int W4  = 26;
  localparam int BLK = 128;

  logic                 clk;
  logic                 rst;
  logic signed [DW-1:0] din;
  logic                 en;
  logic [W4-1:0]        dout;

  int checks;
  int failures;

  baseline_core #(.DATA_WIDTH(DW), .W1(W1), .W2(W2), .W3(W3), .W4(W4)) dut (
    .clk(clk), .rst(rst), .din(din), .en(en), .dout(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic signed [DW-1:0] v, input int n);
    repeat (n) begin
      din = v;
      en  = 1'b1;
      @(posedge clk);
      #1;
    end
    en  = 1'b0;
    din = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #3;
    rst = 1'b1;
    wait_edges(1);
  endtask

  task automatic test_reset();
    int lat;
    checks++;
    if (dout !== '0) begin
      failures++;
      $display("FAIL reset_state dout=%0d expected=0", dout);
    end
    rst = 1'b1;
    wait_edges(1);
    feed(16'sd1, 100);
    din = 16'sd1;
    en  = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (dout !== '0 || dut.r_sum !== '0 || dut.u_stage1.r_acc !== '0) begin
      failures++;
      $display("FAIL async_reset dout=%0d sum=%0d acc1=%0d expected=0",
               dout, dut.r_sum, dut.u_stage1.r_acc);
    end
    #2;
    rst = 1'b1;
    wait_edges(1);
    en = 1'b0;
    apply_reset();
    feed(16'sd1, BLK);
    lat = 0;
    while (dout === '0 && lat < 10) begin
      wait_edges(1);
      lat++;
    end
    checks++;
    if (lat != 3) begin
      failures++;
      $display("FAIL first_latency clocks=%0d expected=3", lat);
    end
    checks++;
    if (dout !== W4'(BLK)) begin
      failures++;
      $display("FAIL first_block dout=%0d expected=%0d", dout, BLK);
    end
  endtask

  task automatic test_const_ones();
    longint exp;
    apply_reset();
    for (int b = 1; b <= 10; b++) begin
      feed(16'sd1, BLK);
      wait_edges(3);
      exp = (b > 8 ? 8 : b) * BLK;
      checks++;
      if (dout !== W4'(exp)) begin
        failures++;
        $display("FAIL ones_block%0d dout=%0d expected=%0d", b, dout, exp);
      end
    end
    wait_edges(50);
    checks++;
    if (dout !== W4'(8 * BLK)) begin
      failures++;
      $display("FAIL ones_hold dout=%0d expected=%0d", dout, 8 * BLK);
    end
  endtask

  task automatic test_neg_full();
    longint exp;
    apply_reset();
    feed(-16'sd32768, 8 * BLK);
    wait_edges(3);
    exp = 64'd32767 * 8 * BLK;
    checks++;
    if (dout !== W4'(exp)) begin
      failures++;
      $display("FAIL neg_full dout=%0d expected=%0d", dout, exp);
    end
    checks++;
    if (dout[W4-1] !== 1'b0) begin
      failures++;
      $display("FAIL neg_msb dout_msb=%0b expected=0", dout[W4-1]);
    end
  endtask

  task automatic test_en_toggle();
    apply_reset();
    for (int i = 0; i < 2 * (BLK - 1); i++) begin
      en  = (i % 2 == 0);
      din = en ? 16'sd5 : 16'sd1000;
      @(posedge clk);
      #1;
    end
    en  = 1'b0;
    din = 16'sd1000;
    wait_edges(10);
    checks++;
    if (dout !== '0) begin
      failures++;
      $display("FAIL en_partial dout=%0d expected=0", dout);
    end
    feed(16'sd5, 1);
    din = 16'sd1000;
    wait_edges(3);
    checks++;
    if (dout !== W4'(5 * BLK)) begin
      failures++;
      $display("FAIL en_toggle dout=%0d expected=%0d", dout, 5 * BLK);
    end
  endtask

  task automatic test_window_slide();
    apply_reset();
    feed(16'sd2, 8 * BLK);
    wait_edges(3);
    checks++;
    if (dout !== W4'(16 * BLK)) begin
      failures++;
      $display("FAIL slide_full dout=%0d expected=%0d", dout, 16 * BLK);
    end
    feed(16'sd0, BLK);
    wait_edges(3);
    checks++;
    if (dout !== W4'(14 * BLK)) begin
      failures++;
      $display("FAIL slide_drop dout=%0d expected=%0d", dout, 14 * BLK);
    end
  endtask

  task automatic test_mixed_sign();
    apply_reset();
    for (int b = 1; b <= 2; b++) begin
      for (int i = 0; i < BLK; i++) begin
        din = (i % 2 == 0) ? 16'sd100 : -16'sd100;
        en  = 1'b1;
        @(posedge clk);
        #1;
      end
      en = 1'b0;
      wait_edges(3);
      checks++;
      if (dout !== W4'(b * 100 * BLK)) begin
        failures++;
        $display("FAIL mixed_block%0d dout=%0d expected=%0d", b, dout, b * 100 * BLK);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    din      = '0;
    en       = 1'b0;
    wait_edges(1);
    test_reset();
    test_const_ones();
    test_neg_full();
    test_en_toggle();
    test_window_slide();
    test_mixed_sign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
